// File: rtl/ofdm_framer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ofdm_framer_pkg
//  Desc     : Shared types and constants for the OFDM frame scheduler.
//  Revision : 1.0
// ============================================================================
package ofdm_framer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } sched_state_t;

    localparam int BEATS_PER_SYMBOL_DEF = 20;
    localparam int TDATA_WIDTH_DEF      = 40;

    localparam logic [1:0] c_st_idle = IDLE;
    localparam logic [1:0] c_st_sync = SYNC;
    localparam logic [1:0] c_st_data = DATA;
    localparam logic [1:0] c_st_gap  = GAP;

    // Beat counter width; a one-beat symbol still needs a 1-bit register.
    function automatic int beat_cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ofdm_symbol_counter.sv
`default_nettype none
// ============================================================================
//  Module   : ofdm_symbol_counter
//  Desc     : Beat/symbol position tracker producing tlast, symbol-end and
//             last-symbol indications for the frame scheduler.
//  Revision : 1.0
// ============================================================================
module ofdm_symbol_counter
    import ofdm_framer_pkg::*;
#(
    parameter int BEATS_PER_SYMBOL = BEATS_PER_SYMBOL_DEF,
    parameter int SYM_CNT_WIDTH    = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_beat,
    input  logic [SYM_CNT_WIDTH-1:0] i_last_sym_idx,
    output logic                     o_first_beat,
    output logic                     o_tlast,
    output logic                     o_sym_end,
    output logic                     o_last_sym
);

    localparam int BEAT_W = beat_cnt_width(BEATS_PER_SYMBOL);
    localparam logic [BEAT_W-1:0] c_last_beat = BEAT_W'(BEATS_PER_SYMBOL - 1);

    logic [BEAT_W-1:0]        r_beat_cnt;
    logic [SYM_CNT_WIDTH-1:0] r_sym_cnt;
    logic                     w_tlast;

    assign w_tlast      = (r_beat_cnt == c_last_beat);
    assign o_tlast      = w_tlast;
    assign o_sym_end    = i_beat & w_tlast;
    assign o_first_beat = (r_beat_cnt == '0) && (r_sym_cnt == '0);
    assign o_last_sym   = (r_sym_cnt == i_last_sym_idx);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_beat_cnt <= '0;
            r_sym_cnt  <= '0;
        end else if (i_beat) begin
            if (w_tlast) begin
                r_beat_cnt <= '0;
                r_sym_cnt  <= r_sym_cnt + SYM_CNT_WIDTH'(1);
            end else begin
                r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ofdm_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : ofdm_frame_scheduler
//  Desc     : Frame sequencer muxing sync and payload AXI-Stream sources into
//             sync + payload symbol frames separated by a programmable gap.
//  Revision : 1.0
// ============================================================================
module ofdm_frame_scheduler
    import ofdm_framer_pkg::*;
#(
    parameter int TDATA_WIDTH      = TDATA_WIDTH_DEF,
    parameter int BEATS_PER_SYMBOL = BEATS_PER_SYMBOL_DEF,
    parameter int SYM_CNT_WIDTH    = 10,
    parameter int GAP_CNT_WIDTH    = 16
) (
    input  logic                     s_axis_data_aclk,
    input  logic                     s_axis_data_areset,
    input  logic                     frame_req,
    input  logic                     frame_abort,
    input  logic [SYM_CNT_WIDTH-1:0] cfg_symbols,
    input  logic [GAP_CNT_WIDTH-1:0] cfg_gap,
    input  logic [TDATA_WIDTH-1:0]   s_axis_sync_tdata,
    input  logic                     s_axis_sync_tvalid,
    output logic                     s_axis_sync_tready,
    input  logic [TDATA_WIDTH-1:0]   s_axis_pay_tdata,
    input  logic                     s_axis_pay_tvalid,
    output logic                     s_axis_pay_tready,
    output logic [TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tuser,
    output logic                     busy,
    output logic                     frame_done,
    output logic [15:0]              underflow_cnt
);

    logic                     clk;
    logic                     rst;

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic                     w_latch;
    logic                     w_enter_gap;

    logic [SYM_CNT_WIDTH-1:0] r_sym_total;
    logic [SYM_CNT_WIDTH-1:0] w_last_sym_idx;
    logic [GAP_CNT_WIDTH-1:0] r_gap_len;
    logic [GAP_CNT_WIDTH-1:0] r_gap_cnt;
    logic [GAP_CNT_WIDTH-1:0] w_gap_last;
    logic                     w_gap_final;

    logic                     r_abort;
    logic                     r_frame_done;
    logic [15:0]              r_underflow;

    logic                     w_sel_sync;
    logic                     w_sel_pay;
    logic                     w_in_frame;
    logic                     w_beat;
    logic                     w_first_beat;
    logic                     w_tlast;
    logic                     w_sym_end;
    logic                     w_last_sym;

    assign clk = s_axis_data_aclk;
    assign rst = s_axis_data_areset;

    // Selection is qualified by reset so no handshake can occur while it is held.
    assign w_sel_sync = !rst && (r_state == c_st_sync);
    assign w_sel_pay  = !rst && (r_state == c_st_data);
    assign w_in_frame = (r_state == c_st_sync) || (r_state == c_st_data);

    assign m_axis_tdata       = w_sel_pay ? s_axis_pay_tdata : s_axis_sync_tdata;
    assign m_axis_tvalid      = (w_sel_sync & s_axis_sync_tvalid) | (w_sel_pay & s_axis_pay_tvalid);
    assign s_axis_sync_tready = w_sel_sync & m_axis_tready;
    assign s_axis_pay_tready  = w_sel_pay & m_axis_tready;
    assign m_axis_tlast       = (w_sel_sync | w_sel_pay) & w_tlast;
    assign m_axis_tuser       = w_sel_sync & w_first_beat;

    assign busy          = (r_state != c_st_idle);
    assign frame_done    = r_frame_done;
    assign underflow_cnt = r_underflow;

    assign w_beat         = m_axis_tvalid & m_axis_tready;
    assign w_last_sym_idx = r_sym_total - SYM_CNT_WIDTH'(1);
    assign w_gap_last     = (r_gap_len == '0) ? '0 : (r_gap_len - GAP_CNT_WIDTH'(1));
    assign w_gap_final    = (r_gap_cnt == w_gap_last);

    ofdm_symbol_counter #(
        .BEATS_PER_SYMBOL (BEATS_PER_SYMBOL),
        .SYM_CNT_WIDTH    (SYM_CNT_WIDTH)
    ) u_symbol_counter (
        .clk            (clk),
        .rst            (rst),
        .i_clear        (!w_in_frame),
        .i_beat         (w_beat),
        .i_last_sym_idx (w_last_sym_idx),
        .o_first_beat   (w_first_beat),
        .o_tlast        (w_tlast),
        .o_sym_end      (w_sym_end),
        .o_last_sym     (w_last_sym)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_enter_gap = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (frame_req) begin
                    w_state_nxt = c_st_sync;
                    w_latch     = 1'b1;
                end
            end
            c_st_sync: begin
                if (w_sym_end) begin
                    if (r_abort || (r_sym_total == SYM_CNT_WIDTH'(1))) begin
                        w_state_nxt = c_st_gap;
                        w_enter_gap = 1'b1;
                    end else begin
                        w_state_nxt = c_st_data;
                    end
                end
            end
            c_st_data: begin
                if (w_sym_end && (r_abort || w_last_sym)) begin
                    w_state_nxt = c_st_gap;
                    w_enter_gap = 1'b1;
                end
            end
            c_st_gap: begin
                if (w_gap_final) begin
                    if (frame_req) begin
                        w_state_nxt = c_st_sync;
                        w_latch     = 1'b1;
                    end else begin
                        w_state_nxt = c_st_idle;
                    end
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_sym_total  <= SYM_CNT_WIDTH'(1);
            r_gap_len    <= '0;
            r_gap_cnt    <= '0;
            r_abort      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= w_enter_gap;
            if (w_latch) begin
                r_sym_total <= (cfg_symbols == '0) ? SYM_CNT_WIDTH'(1) : cfg_symbols;
                r_gap_len   <= cfg_gap;
            end
            if ((r_state == c_st_gap) && !w_gap_final) begin
                r_gap_cnt <= r_gap_cnt + GAP_CNT_WIDTH'(1);
            end else begin
                r_gap_cnt <= '0;
            end
            // An abort pulse landing on the frame's final beat is absorbed by the gap entry.
            if (w_enter_gap) begin
                r_abort <= 1'b0;
            end else if (frame_abort && w_in_frame) begin
                r_abort <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_underflow <= '0;
        end else if ((r_state == c_st_data) && m_axis_tready && !s_axis_pay_tvalid
                     && (r_underflow != 16'hFFFF)) begin
            r_underflow <= r_underflow + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ofdm_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ofdm_frame_scheduler
//  Desc     : Self-checking bench comparing the scheduler against a frame
//             position model (beats emitted, frame length, gap remaining).
//  Revision : 1.0
// ============================================================================
module tb_ofdm_frame_scheduler;

    localparam int TDW = 40;
    localparam int BPS = 20;
    localparam int SW  = 10;
    localparam int GW  = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           frame_req;
    logic           frame_abort;
    logic [SW-1:0]  cfg_symbols;
    logic [GW-1:0]  cfg_gap;
    logic [TDW-1:0] s_sync_tdata;
    logic           s_sync_tvalid;
    logic           s_sync_tready;
    logic [TDW-1:0] s_pay_tdata;
    logic           s_pay_tvalid;
    logic           s_pay_tready;
    logic [TDW-1:0] m_tdata;
    logic           m_tvalid;
    logic           m_tready;
    logic           m_tlast;
    logic           m_tuser;
    logic           busy;
    logic           frame_done;
    logic [15:0]    underflow_cnt;

    always #5 clk = ~clk;

    ofdm_frame_scheduler #(
        .TDATA_WIDTH      (TDW),
        .BEATS_PER_SYMBOL (BPS),
        .SYM_CNT_WIDTH    (SW),
        .GAP_CNT_WIDTH    (GW)
    ) dut (
        .s_axis_data_aclk   (clk),
        .s_axis_data_areset (rst),
        .frame_req          (frame_req),
        .frame_abort        (frame_abort),
        .cfg_symbols        (cfg_symbols),
        .cfg_gap            (cfg_gap),
        .s_axis_sync_tdata  (s_sync_tdata),
        .s_axis_sync_tvalid (s_sync_tvalid),
        .s_axis_sync_tready (s_sync_tready),
        .s_axis_pay_tdata   (s_pay_tdata),
        .s_axis_pay_tvalid  (s_pay_tvalid),
        .s_axis_pay_tready  (s_pay_tready),
        .m_axis_tdata       (m_tdata),
        .m_axis_tvalid      (m_tvalid),
        .m_axis_tready      (m_tready),
        .m_axis_tlast       (m_tlast),
        .m_axis_tuser       (m_tuser),
        .busy               (busy),
        .frame_done         (frame_done),
        .underflow_cnt      (underflow_cnt)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: where we are in the frame, counted in beats.
    bit          md_in_frame = 0;
    bit          md_in_gap   = 0;
    bit          md_abort    = 0;
    bit          md_done     = 0;
    int          md_pos      = 0;
    int          md_len      = 0;
    int          md_gap_cfg  = 0;
    int          md_gap_left = 0;
    int          md_uf       = 0;
    int          md_starts   = 0;
    int          q_len[$];

    logic [31:0] sync_seq = 0;
    logic [31:0] pay_seq  = 0;
    bit          hs_sync, hs_pay;
    bit          rdy_rand = 0, vld_rand = 0, cfg_rand = 0, req_rand = 0, abort_rand = 0;
    int          starve_at = -1, starve_left = 0, abort_at = -1, rst_at = -1, rst_cnt = 0;
    int          dut_done_cnt = 0;

    task automatic model_start();
        md_in_frame = 1;
        md_pos      = 0;
        md_len      = BPS * ((cfg_symbols == 0) ? 1 : int'(cfg_symbols));
        md_gap_cfg  = int'(cfg_gap);
        md_abort    = 0;
        md_starts++;
    endtask

    task automatic check_and_model();
        int   sel;
        logic vld_sel;
        bit   hs;
        bit   abort_new;
        sel = 0;
        if (!rst && md_in_frame) sel = (md_pos < BPS) ? 1 : 2;
        vld_sel = (sel == 1) ? s_sync_tvalid : (sel == 2) ? s_pay_tvalid : 1'b0;
        hs = (sel != 0) && vld_sel && m_tready;

        chk("busy", busy, md_in_frame || md_in_gap);
        chk("m_tvalid", m_tvalid, vld_sel);
        chk("sync_tready", s_sync_tready, (sel == 1) && m_tready);
        chk("pay_tready", s_pay_tready, (sel == 2) && m_tready);
        chk("frame_done", frame_done, md_done);
        chk("underflow", underflow_cnt, md_uf);
        if (hs) begin
            chk("tdata", m_tdata, (sel == 1) ? {8'h5A, sync_seq} : {8'hC3, pay_seq});
            chk("tlast", m_tlast, (md_pos % BPS) == BPS - 1);
            chk("tuser", m_tuser, md_pos == 0);
        end
        if (frame_done) dut_done_cnt++;
        hs_sync = s_sync_tvalid && s_sync_tready;
        hs_pay  = s_pay_tvalid && s_pay_tready;

        if (!rst && sel == 2 && m_tready && !s_pay_tvalid && md_uf < 16'hFFFF) md_uf++;
        md_done = 0;
        if (rst) begin
            md_in_frame = 0;
            md_in_gap   = 0;
            md_abort    = 0;
            md_uf       = 0;
        end else if (md_in_frame) begin
            abort_new = md_abort | frame_abort;
            if (hs) begin
                md_pos++;
                if ((md_pos % BPS) == 0 && (md_pos == md_len || md_abort)) begin
                    q_len.push_back(md_pos);
                    md_in_frame = 0;
                    md_in_gap   = 1;
                    md_gap_left = (md_gap_cfg == 0) ? 1 : md_gap_cfg;
                    md_done     = 1;
                    abort_new   = 0;
                end
            end
            md_abort = abort_new;
        end else if (md_in_gap) begin
            md_gap_left--;
            if (md_gap_left == 0) begin
                md_in_gap = 0;
                if (frame_req) model_start();
            end
        end else if (frame_req) begin
            model_start();
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_and_model();
        @(posedge clk);
        #1;
        if (hs_sync) sync_seq++;
        if (hs_pay)  pay_seq++;
        rst = (rst_cnt > 0);
        if (rst_cnt > 0) rst_cnt--;
        if (rst_at >= 0 && md_in_frame && md_pos == rst_at) begin
            rst    = 1'b1;
            rst_at = -1;
        end
        frame_abort = 1'b0;
        if (abort_at >= 0 && md_in_frame && md_pos == abort_at) begin
            frame_abort = 1'b1;
            abort_at    = -1;
        end else if (abort_rand && $urandom_range(0, 49) == 0) begin
            frame_abort = 1'b1;
        end
        m_tready      = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        s_sync_tvalid = vld_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (starve_at >= 0 && md_in_frame && md_pos == starve_at) begin
            starve_left = 7;
            starve_at   = -1;
        end
        if (starve_left > 0) begin
            s_pay_tvalid = 1'b0;
            starve_left--;
        end else begin
            s_pay_tvalid = vld_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (cfg_rand) begin
            cfg_symbols = SW'($urandom_range(0, 4));
            cfg_gap     = GW'($urandom_range(0, 5));
        end
        if (req_rand) frame_req = ($urandom_range(0, 5) == 0);
        s_sync_tdata = {8'h5A, sync_seq};
        s_pay_tdata  = {8'hC3, pay_seq};
    endtask

    task automatic run_idle(input int max_cycles);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((busy || md_in_frame || md_in_gap) && n < max_cycles);
        chk("idle_wait", busy, 1'b0);
    endtask

    task automatic one_frame(input int syms, input int gap);
        cfg_symbols = SW'(syms);
        cfg_gap     = GW'(gap);
        frame_req   = 1'b1;
        tick();
        frame_req = 1'b0;
    endtask

    int done0;
    int s0;
    int n;

    initial begin
        rst = 1'b1; rst_cnt = 2;
        frame_req = 1'b0; frame_abort = 1'b0;
        cfg_symbols = SW'(3); cfg_gap = GW'(4);
        m_tready = 1'b1; s_sync_tvalid = 1'b1; s_pay_tvalid = 1'b1;
        s_sync_tdata = {8'h5A, sync_seq};
        s_pay_tdata  = {8'hC3, pay_seq};

        repeat (3) tick();
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_tvalid", m_tvalid, 1'b0);
        chk("rst_uf", underflow_cnt, 16'd0);
        chk("rst_done", frame_done, 1'b0);

        // Basic three-symbol frame
        q_len.delete(); done0 = dut_done_cnt;
        one_frame(3, 4);
        run_idle(300);
        chk("basic_frames", q_len.size(), 1);
        chk("basic_len", q_len[0], 60);
        chk("basic_done", dut_done_cnt - done0, 1);

        // Output backpressure
        q_len.delete(); rdy_rand = 1;
        one_frame(2, 2);
        run_idle(600);
        rdy_rand = 0;
        chk("bp_len", q_len[0], 40);
        chk("bp_uf", underflow_cnt, 16'd0);

        // Payload starvation mid-symbol
        q_len.delete(); starve_at = 25;
        one_frame(3, 1);
        run_idle(300);
        chk("starve_len", q_len[0], 60);
        chk("starve_uf", underflow_cnt, 16'd7);

        // Abort in third symbol, then abort during sync
        q_len.delete(); done0 = dut_done_cnt; abort_at = 44;
        one_frame(10, 3);
        run_idle(400);
        chk("abort_len", q_len[0], 60);
        chk("abort_done", dut_done_cnt - done0, 1);
        q_len.delete(); abort_at = 5;
        one_frame(4, 0);
        run_idle(300);
        chk("abort_sync_len", q_len[0], 20);

        // Back-to-back with zero gap; second frame latches cfg_symbols=0
        q_len.delete(); done0 = dut_done_cnt; s0 = md_starts;
        cfg_symbols = SW'(2); cfg_gap = GW'(0); frame_req = 1'b1;
        tick();
        cfg_symbols = SW'(0);
        n = 0;
        while (md_starts < s0 + 2 && n < 400) begin
            tick();
            n++;
        end
        frame_req = 1'b0;
        run_idle(300);
        chk("b2b_frames", q_len.size(), 2);
        chk("b2b_len0", q_len[0], 40);
        chk("b2b_len1", q_len[1], 20);
        chk("b2b_done", dut_done_cnt - done0, 2);

        // Reset at beat 33 of a frame
        done0 = dut_done_cnt; rst_at = 32;
        one_frame(3, 2);
        n = 0;
        while (!rst && n < 200) begin
            tick();
            n++;
        end
        tick();
        #1;
        chk("mr_busy", busy, 1'b0);
        chk("mr_tvalid", m_tvalid, 1'b0);
        chk("mr_sync_tready", s_sync_tready, 1'b0);
        chk("mr_pay_tready", s_pay_tready, 1'b0);
        chk("mr_uf", underflow_cnt, 16'd0);
        chk("mr_done", frame_done, 1'b0);
        repeat (10) tick();
        chk("mr_no_done", dut_done_cnt - done0, 0);

        // Randomized soak: random config, requests, aborts, valid and ready
        rdy_rand = 1; vld_rand = 1; cfg_rand = 1; req_rand = 1; abort_rand = 1;
        repeat (3000) tick();
        rdy_rand = 0; vld_rand = 0; cfg_rand = 0; req_rand = 0; abort_rand = 0;
        frame_req = 1'b0;
        run_idle(1000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
